bit_deserializer: RTL and testbench
===================================

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per assembled word.
REQ-002 Parameter CNT_W, default 8: width of the delivered-word counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock, shared with the upstream CMOS flip-flop stage.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 bit_in  input  1  serial data taken from the flip-flop q output.
REQ-007 bit_en  input  1  bit_in is valid this cycle; sampled on the rising edge of clk.
REQ-008 out_data  output  WIDTH  assembled word.
REQ-009 out_valid  output  1  out_data holds an undelivered word.
REQ-010 out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-011 overflow  output  1  sticky flag: a completed word was dropped.
REQ-012 ovf_clr  input  1  synchronous clear of overflow.
REQ-013 word_count  output  CNT_W  number of words delivered, modulo 2^CNT_W.

Function
REQ-014 Each clk edge with bit_en=1 SHALL shift bit_in into the shift register MSB-first: the first bit received ends up in out_data[WIDTH-1].
REQ-015 A bit counter SHALL count 0..WIDTH-1 and wrap to 0 on the WIDTH-th accepted bit; bit_en=0 SHALL hold both the counter and the shift register.
REQ-016 The output holding register SHALL be a two-state FSM. In EMPTY, out_valid=0. In FULL, out_valid=1.
REQ-017 The word is complete on the edge that accepts its WIDTH-th bit. On that edge, if the FSM is EMPTY, or FULL with out_ready=1, the block SHALL load the word into out_data and the FSM SHALL be FULL after that edge.
REQ-018 Latency: out_valid SHALL rise in the cycle immediately after the edge that accepts the last bit.
REQ-019 On FULL with out_ready=1 and no word completing, the FSM SHALL return to EMPTY.
REQ-020 On a word completing while FULL with out_ready=0, the block SHALL drop the new word, leave out_data unchanged, and set overflow; bit assembly SHALL continue uninterrupted.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-022 word_count SHALL increment by 1 on every transfer and wrap from 2^CNT_W-1 to 0.
REQ-023 ovf_clr=1 SHALL clear overflow. If a drop and ovf_clr occur on the same edge, set wins and overflow=1.
REQ-024 bit_en and out_ready SHALL be handled independently, so a word delivery and bit collection can occur on the same edge.

Reset
REQ-025 While rst_n=0, the block SHALL hold out_data=0, out_valid=0, overflow=0, word_count=0, bit counter=0, shift register=0, and FSM=EMPTY.
REQ-026 Reset asserted mid-word SHALL discard the partial word, and a held undelivered word SHALL be lost.
REQ-027 After rst_n deasserts, the first bit_en edge SHALL be treated as bit 0 of a new word.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (EMPTY=0, FULL=1) and the default WIDTH and CNT_W constants.
REQ-029 The shift register and bit counter SHALL be a sub-module named bit_shifter, which outputs word and word_done. The FSM, overflow logic and counter SHALL be in the top level.

Verification
REQ-030 Bits 1,0,1,0,0,1,0,1 with bit_en=1 every cycle and out_ready=1 -> out_data=8'hA5 and out_valid=1 one cycle after bit 8; word_count=1 after the transfer.
REQ-031 Two consecutive words 8'hFF then 8'h00 with out_ready=0 throughout -> out_data stays 8'hFF, overflow=1, word_count=0.
REQ-032 bit_en toggled 1,0,1,0 across word 8'h3C -> word delivered correctly; out_valid rises 1 cycle after the 8th enabled bit.
REQ-033 rst_n pulsed low after 5 bits of a word -> all outputs 0; the next 8 bits 8'h81 yield out_data=8'h81.
REQ-034 256 transfers with CNT_W=8 -> word_count wraps to 0; ovf_clr issued on the same edge as a drop -> overflow stays 1.
REQ-035 Stream the CMOS flip-flop q output with a d pattern giving 8'h5A, out_ready held high -> out_data=8'h5A.

Source files
------------

// File: rtl/bit_deserializer_pkg.sv
// Shared constants and output-holding FSM encoding for the bit deserializer.
package bit_deserializer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/bit_deserializer_bit_shifter.sv
// MSB-first shift register with a bit counter; flags the edge that accepts
// the last bit of a word and presents the word as it will look after that edge.
module bit_shifter
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] word,
  output logic             word_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_r;
  logic [BW-1:0]    cnt_r;

  // Word lookahead lets the top capture a complete word on its final bit edge.
  always_comb begin
    word      = {shift_r[WIDTH-2:0], bit_in};
    word_done = bit_en && (cnt_r == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {BW{1'b0}};
    end else if (bit_en) begin
      shift_r <= word;
      cnt_r   <= (cnt_r == LAST_BIT) ? {BW{1'b0}} : cnt_r + BW'(1);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer with a single-word valid/ready output holding
// register, a sticky overflow flag for dropped words and a delivered-word counter.
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] word_count
);

  hold_state_e      state_r;
  logic [WIDTH-1:0] data_r;
  logic             ovf_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] word_s;
  logic             word_done_s;
  logic             drop_s;

  bit_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // A completed word is dropped only when the held word is not leaving this edge.
  always_comb begin
    drop_s = word_done_s && (state_r == FULL) && !out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      data_r  <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (word_done_s) begin
            data_r  <= word_s;
            state_r <= FULL;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            count_r <= count_r + CNT_W'(1);
            if (word_done_s) begin
              data_r  <= word_s;
              state_r <= FULL;
            end else begin
              state_r <= EMPTY;
            end
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase

      // Setting on a drop takes priority over a clear on the same edge.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign out_data   = data_r;
  assign out_valid  = (state_r == FULL);
  assign overflow   = ovf_r;
  assign word_count = count_r;

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a transaction-level model built from bit queues and word-level arithmetic.
module tb_bit_deserializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_drv = 1'b0;
  logic             en_drv = 1'b0;
  logic             out_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             use_ff = 1'b0;
  logic             ff_d = 1'b0;
  logic             ff_en_d = 1'b0;
  logic             ff_q = 1'b0;
  logic             ff_en_q = 1'b0;
  logic             bit_in;
  logic             bit_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             overflow;
  logic [CNT_W-1:0] word_count;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit             m_bits[$];
  logic [WIDTH-1:0] m_data;
  bit             m_valid;
  bit             m_ovf;
  int             m_count;

  assign bit_in = use_ff ? ff_q : bit_drv;
  assign bit_en = use_ff ? ff_en_q : en_drv;

  bit_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Upstream CMOS flip-flop stage feeding the deserializer
  always @(posedge clk) begin
    ff_q    <= ff_d;
    ff_en_q <= ff_en_d;
  end

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_count = 0;
  endtask

  task automatic model_edge(input bit b, input bit e, input bit r, input bit c);
    bit done = 1'b0;
    int w = 0;
    bit was_valid = m_valid;
    if (e) begin
      m_bits.push_back(b);
      if (m_bits.size() == WIDTH) begin
        foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (was_valid && r) m_count = (m_count + 1) % (1 << CNT_W);
    if (done && was_valid && !r) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (done && (!was_valid || r)) begin
      m_data  = WIDTH'(w);
      m_valid = 1'b1;
    end else if (was_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_result({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_result({tag, ".data"}, 32'(out_data), 32'(m_data));
    check_result({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check_result({tag, ".count"}, 32'(word_count), 32'(m_count));
  endtask

  // One clock: drive, sample actual DUT inputs mid-cycle, advance the model after the edge.
  task automatic step(input string tag, input logic b, input logic e, input logic r, input logic c);
    bit sb, se, sr, sc;
    bit_drv = b; en_drv = e; out_ready = r; ovf_clr = c;
    ff_d = b; ff_en_d = e;
    @(negedge clk);
    sb = bit_in; se = bit_en; sr = out_ready; sc = ovf_clr;
    @(posedge clk);
    #1;
    model_edge(sb, se, sr, sc);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_drv = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    ff_d = 1'b0; ff_en_d = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    check_result("reset.data0", 32'(out_data), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input string tag, input logic [WIDTH-1:0] w, input logic r,
                           input logic clr_last, input bit gaps);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(tag, w[i], 1'b1, r, (i == 0) ? clr_last : 1'b0);
      if (gaps && i > 0) step(tag, 1'b0, 1'b0, r, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic word, valid one cycle after 8th bit, then transfer
    send_word("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    check_result("a5.data", 32'(out_data), 32'hA5);
    check_result("a5.valid", 32'(out_valid), 32'h1);
    step("a5x", 1'b0, 1'b0, 1'b1, 1'b0);
    check_result("a5.count", 32'(word_count), 32'h1);

    // Overflow: second word dropped while held word not accepted
    do_reset();
    send_word("ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    send_word("00", 8'h00, 1'b0, 1'b0, 1'b0);
    check_result("ovf.data", 32'(out_data), 32'hFF);
    check_result("ovf.flag", 32'(overflow), 32'h1);
    check_result("ovf.count", 32'(word_count), 32'h0);

    // Gapped bit_en
    do_reset();
    send_word("3c", 8'h3C, 1'b0, 1'b0, 1'b1);
    check_result("3c.data", 32'(out_data), 32'h3C);
    check_result("3c.valid", 32'(out_valid), 32'h1);

    // Reset mid-word, then a fresh word
    do_reset();
    for (int i = 0; i < 5; i++) step("part", 1'(i), 1'b1, 1'b0, 1'b0);
    do_reset();
    check_result("mid.valid", 32'(out_valid), 32'h0);
    send_word("81", 8'h81, 1'b0, 1'b0, 1'b0);
    check_result("81.data", 32'(out_data), 32'h81);

    // 256 transfers wrap the counter
    do_reset();
    for (int n = 0; n < 256; n++) send_word("wrap", 8'(n * 7 + 3), 1'b1, 1'b0, 1'b0);
    step("wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    check_result("wrap.count", 32'(word_count), 32'h0);

    // Drop coincident with clear: set wins; then clear alone
    send_word("h1", 8'h11, 1'b0, 1'b0, 1'b0);
    send_word("h2", 8'h22, 1'b0, 1'b1, 1'b0);
    check_result("setwins.flag", 32'(overflow), 32'h1);
    check_result("setwins.data", 32'(out_data), 32'h11);
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    check_result("clr.flag", 32'(overflow), 32'h0);

    // Bits streamed through the upstream flip-flop
    do_reset();
    use_ff = 1'b1;
    send_word("ff5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    step("ff5a", 1'b0, 1'b0, 1'b1, 1'b0);
    check_result("ff5a.data", 32'(out_data), 32'h5A);
    use_ff = 1'b0;

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step("rnd", 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
